// File: rtl/operand_mux_arb.sv
// operand_mux_arb: NUM_IN-way signed operand selector (explicit select or round-robin)
// feeding a registered valid/ready output with a one-entry skid register.
// Optional macro OPERAND_MUX_ARB_PARITY_EN adds out_parity (XOR-reduce of out_data).
module operand_mux_arb #(
  parameter int WIDTH  = 256,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    sel_mode,
  input  logic [SEL_W-1:0]        select,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef OPERAND_MUX_ARB_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // Producers hold valid/data until accepted; in_ready never looks at out_ready,
  // so the upstream ready path starts from the skid_valid flop only.

  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic             accept;

  logic [SEL_W-1:0] rr_ptr;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_src;

  // Round-robin picks the valid channel at the smallest forward distance from rr_ptr.
  always_comb begin : grant_logic
    int best_d;
    int d;
    grant_valid = 1'b0;
    grant       = '0;
    best_d      = NUM_IN;
    d           = 0;
    if (!sel_mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (select == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant       = SEL_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        d = i - int'(rr_ptr) - 1;
        if (d < 0) begin
          d = d + NUM_IN;
        end
        if (in_valid[i] && d < best_d) begin
          best_d      = d;
          grant_valid = 1'b1;
          grant       = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin : data_mux
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : ready_logic
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = grant_valid && !skid_valid && (grant == SEL_W'(i));
    end
  end

  assign accept = grant_valid && !skid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_src   <= '0;
      rr_ptr     <= SEL_W'(NUM_IN - 1);
    end else begin
      if (accept) begin
        rr_ptr <= grant;
      end
      if (!out_valid || out_ready) begin
        // A full skid always drains first; in_ready was low so nothing new arrives.
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          out_src    <= skid_src;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_data  <= grant_data;
          out_src   <= grant;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= grant_data;
        skid_src   <= grant;
      end
    end
  end

`ifdef OPERAND_MUX_ARB_PARITY_EN
  logic skid_parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_parity  <= 1'b0;
      skid_parity <= 1'b0;
    end else begin
      if (!out_valid || out_ready) begin
        if (skid_valid) begin
          out_parity <= skid_parity;
        end else if (accept) begin
          out_parity <= ^grant_data;
        end
      end else if (accept) begin
        skid_parity <= ^grant_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_operand_mux_arb.sv
// Bench for operand_mux_arb: directed scenario tasks plus a randomized run checked
// against a queue-based model of in-flight operands (W=256/N=4 and W=16/N=3 instances).
module tb_operand_mux_arb;

  localparam int W  = 256;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int W3 = 16;
  localparam int N3 = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           sel_mode;
  logic [SW-1:0]  select;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_valid;
  logic           out_ready;

  logic [N3*W3-1:0] d3_in_data;
  logic [N3-1:0]    d3_in_valid;
  logic [N3-1:0]    d3_in_ready;
  logic             d3_sel_mode;
  logic [SW-1:0]    d3_select;
  logic [W3-1:0]    d3_out_data;
  logic [SW-1:0]    d3_out_src;
  logic             d3_out_valid;
  logic             d3_out_ready;

`ifdef OPERAND_MUX_ARB_PARITY_EN
  logic out_parity;
  logic d3_out_parity;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [W+SW-1:0] exp_q[$];
  int last_g;

  operand_mux_arb #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel_mode(sel_mode), .select(select), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef OPERAND_MUX_ARB_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  operand_mux_arb #(.WIDTH(W3), .NUM_IN(N3)) dut3 (
    .clk(clk), .reset(reset), .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .sel_mode(d3_sel_mode), .select(d3_select), .out_data(d3_out_data), .out_src(d3_out_src),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready)
`ifdef OPERAND_MUX_ARB_PARITY_EN
    , .out_parity(d3_out_parity)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic idle();
    in_valid     = '0;
    d3_in_valid  = '0;
    out_ready    = 1'b1;
    d3_out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic pulse_reset();
    reset       = 1'b1;
    in_valid    = '0;
    d3_in_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Grant predicted from the arbitration rules: explicit index, or first valid after last grant.
  function automatic int model_grant(input logic mode, input logic [SW-1:0] sel,
                                     input logic [N-1:0] v, input int last);
    if (!mode) return v[sel] ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = '0; d3_in_valid = '0; sel_mode = 1'b0; select = '0;
    d3_sel_mode = 1'b0; d3_select = '0; out_ready = 1'b1; d3_out_ready = 1'b1;
    in_data = '0; d3_in_data = '0;
    repeat (2) tick();
    reset = 1'b0;
    #3;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_vec++; if (out_src !== '0) begin n_err++; $display("FAIL reset_out_src: got %0d want 0", out_src); end
    n_vec++; if (in_ready !== '0) begin n_err++; $display("FAIL reset_in_ready_idle: got %b want 0000", in_ready); end
    n_vec++; if (d3_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_d3_out_valid: got %b want 0", d3_out_valid); end
    sel_mode = 1'b1; in_valid = 4'b1111;
    #1;
    n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL reset_rr_first: got %b want 0001", in_ready); end
    in_valid = '0; sel_mode = 1'b0;
    tick();
  endtask

  task automatic test_explicit_select();
    sel_mode = 1'b0; select = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    set_ch(0, W'(11)); set_ch(1, W'(22)); set_ch(2, W'(5)); set_ch(3, W'(33));
    #3;
    n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL explicit_in_ready: got %b want 0100", in_ready); end
    tick();
    in_valid = '0;
    #3;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL explicit_out_valid: got %b want 1", out_valid); end
    n_vec++; if (out_data !== W'(5)) begin n_err++; $display("FAIL explicit_out_data: got %h want 5", out_data); end
    n_vec++; if (out_src !== 2'd2) begin n_err++; $display("FAIL explicit_out_src: got %0d want 2", out_src); end
    tick(); #3;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL explicit_drain: got %b want 0", out_valid); end
    idle();
  endtask

  task automatic test_round_robin();
    pulse_reset();
    sel_mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, W'(100 + i));
    for (int c = 0; c <= 8; c++) begin
      #3;
      if (c < 8) begin
        n_vec++; if (in_ready !== N'(1 << (c % N))) begin n_err++;
          $display("FAIL rr_in_ready c=%0d: got %b want %b", c, in_ready, N'(1 << (c % N))); end
      end
      if (c > 0) begin
        n_vec++; if (out_valid !== 1'b1 || out_src !== SW'((c - 1) % N)) begin n_err++;
          $display("FAIL rr_out_src c=%0d: got v=%b src=%0d want v=1 src=%0d", c, out_valid, out_src, (c - 1) % N); end
        n_vec++; if (out_data !== W'(100 + (c - 1) % N)) begin n_err++;
          $display("FAIL rr_out_data c=%0d: got %h want %0d", c, out_data, 100 + (c - 1) % N); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    sel_mode = 1'b0; select = 2'd0; out_ready = 1'b1; in_valid = 4'b0001; set_ch(0, W'(1));
    #3;
    n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL bp_ready0: got %b want 0001", in_ready); end
    tick();
    set_ch(0, W'(2)); out_ready = 1'b0;
    #3;
    n_vec++; if (out_valid !== 1'b1 || out_data !== W'(1)) begin n_err++; $display("FAIL bp_out1: got v=%b d=%h want v=1 d=1", out_valid, out_data); end
    n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL bp_ready1: got %b want 0001", in_ready); end
    tick();
    set_ch(0, W'(3));
    #3;
    n_vec++; if (out_data !== W'(1)) begin n_err++; $display("FAIL bp_hold_a: got %h want 1", out_data); end
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_skid_full_a: got %b want 0000", in_ready); end
    tick(); #3;
    n_vec++; if (out_data !== W'(1) || out_src !== 2'd0) begin n_err++; $display("FAIL bp_hold_b: got d=%h s=%0d want d=1 s=0", out_data, out_src); end
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_skid_full_b: got %b want 0000", in_ready); end
    out_ready = 1'b1;
    tick(); #3;
    n_vec++; if (out_valid !== 1'b1 || out_data !== W'(2)) begin n_err++; $display("FAIL bp_out2: got v=%b d=%h want v=1 d=2", out_valid, out_data); end
    n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL bp_ready_reopen: got %b want 0001", in_ready); end
    tick();
    in_valid = '0;
    #3;
    n_vec++; if (out_valid !== 1'b1 || out_data !== W'(3)) begin n_err++; $display("FAIL bp_out3: got v=%b d=%h want v=1 d=3", out_valid, out_data); end
    tick(); #3;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    idle();
  endtask

  task automatic test_idle_select();
    sel_mode = 1'b0; select = 2'd0; in_valid = 4'b0001; set_ch(0, W'(9)); out_ready = 1'b1;
    tick();
    select = 2'd1; in_valid = 4'b1101;
    #3;
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL idle_sel_ready: got %b want 0000", in_ready); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== W'(9)) begin n_err++; $display("FAIL idle_sel_out: got v=%b d=%h want v=1 d=9", out_valid, out_data); end
    tick(); #3;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_sel_drain: got %b want 0", out_valid); end
    idle();
  endtask

  task automatic test_signed();
    sel_mode = 1'b0; select = 2'd3; in_valid = 4'b1000; out_ready = 1'b1; set_ch(3, {W{1'b1}});
    #3;
    n_vec++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL signed_ready: got %b want 1000", in_ready); end
    tick();
    in_valid = '0;
    #3;
    n_vec++; if (out_data !== {W{1'b1}}) begin n_err++; $display("FAIL signed_data: got %h want all ones", out_data); end
    n_vec++; if (out_src !== 2'd3) begin n_err++; $display("FAIL signed_src: got %0d want 3", out_src); end
`ifdef OPERAND_MUX_ARB_PARITY_EN
    n_vec++; if (out_parity !== 1'b0) begin n_err++; $display("FAIL signed_parity: got %b want 0", out_parity); end
`endif
    idle();
  endtask

  task automatic test_reset_mid_stall();
    pulse_reset();
    sel_mode = 1'b0; select = 2'd0; out_ready = 1'b0; in_valid = 4'b0001; set_ch(0, W'(7));
    tick();
    set_ch(0, W'(8));
    tick(); #3;
    n_vec++; if (out_valid !== 1'b1 || out_data !== W'(7) || in_ready !== 4'b0000) begin n_err++;
      $display("FAIL stall_setup: got v=%b d=%h r=%b want v=1 d=7 r=0000", out_valid, out_data, in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0; sel_mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, W'(40 + i));
    #3;
    n_vec++; if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin n_err++;
      $display("FAIL rst_stall_out: got v=%b d=%h s=%0d want all 0", out_valid, out_data, out_src); end
    n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rst_stall_ready: got %b want 0001", in_ready); end
    tick();
    in_valid = '0;
    #3;
    n_vec++; if (out_valid !== 1'b1 || out_data !== W'(40) || out_src !== 2'd0) begin n_err++;
      $display("FAIL rst_stall_first: got v=%b d=%h s=%0d want v=1 d=28 s=0", out_valid, out_data, out_src); end
    idle();
  endtask

  task automatic test_nonpow2();
    pulse_reset();
    d3_sel_mode = 1'b0; d3_select = 2'd3; d3_in_valid = 3'b111; d3_out_ready = 1'b1;
    d3_in_data = {16'h3333, 16'h2222, 16'h1111};
    #3;
    n_vec++; if (d3_in_ready !== 3'b000) begin n_err++; $display("FAIL np2_sel3_ready: got %b want 000", d3_in_ready); end
    tick(); #3;
    n_vec++; if (d3_out_valid !== 1'b0) begin n_err++; $display("FAIL np2_sel3_out: got %b want 0", d3_out_valid); end
    tick();
    d3_sel_mode = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      #3;
      if (c < 6) begin
        n_vec++; if (d3_in_ready !== N3'(1 << (c % N3))) begin n_err++;
          $display("FAIL np2_rr_ready c=%0d: got %b want %b", c, d3_in_ready, N3'(1 << (c % N3))); end
      end
      if (c > 0) begin
        n_vec++; if (d3_out_valid !== 1'b1 || d3_out_src !== SW'((c - 1) % N3) ||
                     d3_out_data !== W3'(16'h1111 * ((c - 1) % N3 + 1))) begin n_err++;
          $display("FAIL np2_rr_out c=%0d: got v=%b s=%0d d=%h want s=%0d", c, d3_out_valid, d3_out_src, d3_out_data, (c - 1) % N3); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] exp_rdy;
    logic exp_v;
    pulse_reset();
    exp_q.delete();
    last_g = N - 1;
    for (int c = 0; c < 400; c++) begin
      in_valid  = N'($urandom_range(0, 15));
      sel_mode  = 1'($urandom_range(0, 1));
      select    = SW'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_ch(i, rand_word());
      #3;
      g = model_grant(sel_mode, select, in_valid, last_g);
      exp_rdy = (g >= 0 && exp_q.size() < 2) ? N'(1 << g) : '0;
      exp_v = (exp_q.size() != 0);
      n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, exp_rdy); end
      n_vec++; if (out_valid !== exp_v) begin n_err++; $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, exp_v); end
      if (exp_v) begin
        n_vec++; if (out_data !== exp_q[0][W-1:0] || out_src !== exp_q[0][W+SW-1:W]) begin n_err++;
          $display("FAIL rand_out c=%0d: got s=%0d d=%h want s=%0d d=%h", c, out_src, out_data, exp_q[0][W+SW-1:W], exp_q[0][W-1:0]); end
`ifdef OPERAND_MUX_ARB_PARITY_EN
        n_vec++; if (out_parity !== ^exp_q[0][W-1:0]) begin n_err++;
          $display("FAIL rand_parity c=%0d: got %b want %b", c, out_parity, ^exp_q[0][W-1:0]); end
`endif
      end
      if (exp_v && out_ready) void'(exp_q.pop_front());
      if (exp_rdy != '0) begin
        exp_q.push_back({SW'(g), in_data[g*W +: W]});
        last_g = g;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_explicit_select();
    test_round_robin();
    test_backpressure();
    test_idle_select();
    test_signed();
    test_reset_mid_stall();
    test_nonpow2();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
